// File: rtl/imem_uart_loader.sv
// imem_uart_loader: 8N1 UART receiver plus packet parser that writes a length-prefixed
// big-endian program image into instruction memory, holding the CPU until it is complete.
module imem_uart_loader #(
    parameter int D_SIZE       = 32,
    parameter int AW           = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              im_we,
    output logic [AW-1:0]     im_addr,
    output logic [D_SIZE-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err,
    output logic              overflow
);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_LEN_HI, P_LEN_LO, P_WORD, P_FIN, P_DONE} pk_state_t;

    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [16:0] DEPTH    = 17'(2 ** AW);

    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t         rs_q, rs_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              bv_q, bv_d, be_q, be_d;
    logic              frame_err_q, frame_err_d;
    pk_state_t         ps_q, ps_d;
    logic [15:0]       len_q, len_d, idx_q, idx_d;
    logic [1:0]        bc_q, bc_d;
    logic [23:0]       wsh_q, wsh_d;
    logic              im_we_q, im_we_d;
    logic [AW-1:0]     im_addr_q, im_addr_d;
    logic [D_SIZE-1:0] im_wdata_q, im_wdata_d;
    logic              overflow_q, overflow_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= 3'b111;
            rs_q        <= R_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sh_q        <= '0;
            bv_q        <= 1'b0;
            be_q        <= 1'b0;
            frame_err_q <= 1'b0;
            ps_q        <= P_LEN_HI;
            len_q       <= '0;
            idx_q       <= '0;
            bc_q        <= '0;
            wsh_q       <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            {rx_s1_q, rx_s2_q, rx_s3_q} <= {rx, rx_s1_q, rx_s2_q};
            rs_q        <= rs_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            bv_q        <= bv_d;
            be_q        <= be_d;
            frame_err_q <= frame_err_d;
            ps_q        <= ps_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            bc_q        <= bc_d;
            wsh_q       <= wsh_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        rs_d        = rs_q;
        cnt_d       = cnt_q + 16'd1;
        bit_d       = bit_q;
        sh_d        = sh_q;
        bv_d        = 1'b0;
        be_d        = 1'b0;
        frame_err_d = frame_err_q;
        case (rs_q)
            R_IDLE: begin
                cnt_d = '0;
                rs_d  = (rx_s3_q && !rx_s2_q) ? R_START : R_IDLE;
            end
            R_START: if (cnt_q == HALF_END) begin
                cnt_d = '0;
                bit_d = '0;
                rs_d  = rx_s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == BIT_END) begin
                cnt_d = '0;
                sh_d  = {rx_s2_q, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                rs_d  = (bit_q == 3'd7) ? R_STOP : R_DATA;
            end
            R_STOP: if (cnt_q == BIT_END) begin
                rs_d        = R_IDLE;
                bv_d        = rx_s2_q;
                be_d        = !rx_s2_q;
                frame_err_d = frame_err_q | !rx_s2_q;
            end
        endcase
        // A frame error aborts any packet in flight; LEN_HI and DONE are unaffected.
        ps_d       = ps_q;
        len_d      = len_q;
        idx_d      = idx_q;
        bc_d       = bc_q;
        wsh_d      = wsh_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        overflow_d = overflow_q;
        case (ps_q)
            P_LEN_HI: if (bv_q) begin
                len_d[15:8] = sh_q;
                ps_d        = P_LEN_LO;
            end
            P_LEN_LO: if (bv_q) begin
                len_d[7:0] = sh_q;
                overflow_d = overflow_q | ({1'b0, len_q[15:8], sh_q} > DEPTH);
                idx_d      = '0;
                bc_d       = '0;
                ps_d       = ({len_q[15:8], sh_q} == 16'd0) ? P_DONE : P_WORD;
            end else if (be_q) begin
                ps_d = P_LEN_HI;
            end
            P_WORD: if (bv_q) begin
                bc_d  = bc_q + 2'd1;
                wsh_d = {wsh_q[15:0], sh_q};
                if (bc_q == 2'd3) begin
                    im_we_d    = {1'b0, idx_q} < DEPTH;
                    im_addr_d  = im_we_d ? idx_q[AW-1:0] : im_addr_q;
                    im_wdata_d = im_we_d ? D_SIZE'({wsh_q, sh_q}) : im_wdata_q;
                    idx_d      = idx_q + 16'd1;
                    ps_d       = (idx_q == len_q - 16'd1) ? P_FIN : P_WORD;
                end
            end else if (be_q) begin
                ps_d  = P_LEN_HI;
                idx_d = '0;
                bc_d  = '0;
            end
            P_FIN:   ps_d = P_DONE;
            P_DONE:  ps_d = P_DONE;
            default: ps_d = P_LEN_HI;
        endcase
    end

    always_comb begin
        im_we     = im_we_q;
        im_addr   = im_addr_q;
        im_wdata  = im_wdata_q;
        frame_err = frame_err_q;
        overflow  = overflow_q;
        load_done = ps_q == P_DONE;
        cpu_hold  = ps_q != P_DONE;
    end
endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Boot-time loader that receives a program over a UART serial line and writes it word-by-word into the pipeline's instruction memory, holding the processor in reset until the image is complete. Sits directly upstream of the instruction memory / program-counter front end: it drives the memory write port and the processor hold line, so the fetch stage starts only on a fully loaded image. One 8N1 receiver plus a packet FSM, all on the processor clock.

## Interface
- D_SIZE, 32, instruction word width; fixed at 4 bytes.
- AW, 8, instruction-memory word-address width; depth = 2^AW words.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 8.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- im_we  out  1  instruction-memory write strobe, one cycle per word.
- im_addr  out  AW  word address for the write.
- im_wdata  out  D_SIZE  instruction word to write.
- cpu_hold  out  1  high = processor held in reset; low once load completes.
- load_done  out  1  level, high after the last word is written.
- frame_err  out  1  sticky, a stop bit sampled low.
- overflow  out  1  sticky, length field exceeded 2^AW.

## Operation
- Reset values: im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, load_done=0, frame_err=0, overflow=0; both FSMs in idle/LEN_HI.
- rx passes a 2-flop synchronizer before any use.
- RX FSM: IDLE -> START on synchronized falling edge. START: wait CLKS_PER_BIT/2, sample; high = false start -> IDLE, low -> DATA. DATA: 8 samples every CLKS_PER_BIT, LSB first. STOP: sample after CLKS_PER_BIT; high -> byte_valid pulse (internal, 1 cycle) -> IDLE; low -> frame_err=1, byte discarded -> IDLE.
- Packet format: 2-byte word count N (big-endian), then N words, each 4 bytes big-endian (first byte = bits 31:24).
- Packet FSM: LEN_HI -> LEN_LO -> (N=0 ? DONE : WORD). WORD counts bytes 0..3 into a shift register; on 4th byte issue write, increment word index; after word N -> DONE.
- Write: im_addr = word index (0..N-1), im_wdata = assembled word, im_we=1 for exactly one cycle.
- N > 2^AW: overflow=1 at LEN_LO; all N words still consumed, only indices < 2^AW written (im_we suppressed beyond), im_addr never wraps.
- Frame error while in LEN_LO or WORD: packet FSM returns to LEN_HI, word index and byte count cleared; partial word never written; next valid packet loads from address 0.
- DONE: load_done=1, cpu_hold=0; further rx traffic ignored (receiver may run; frame_err still may set). Only rst starts a new load.
- rst asserted at any time, including mid-byte or mid-packet: all outputs to reset values immediately.

## Timing
- rx to internal sampling: 2 cycles synchronizer latency.
- byte_valid: cycle after stop-bit mid-sample.
- im_we: cycle after the 4th byte_valid of a word; im_addr/im_wdata valid same cycle, held until next write.
- load_done rises and cpu_hold falls the cycle after the final im_we (or the cycle after LEN_LO byte_valid when N=0).
- Back-to-back bytes with no idle gap between stop and next start bit must be received.

## Test plan
- Reset, rx held high 200 cycles -> no im_we, cpu_hold=1, all flags 0.
- CLKS_PER_BIT=16; send 00 02, 20 08 00 05, 8C 09 00 04 -> im_we at addr 0 data 0x20080005, addr 1 data 0x8C090004; next cycle load_done=1, cpu_hold=0; later bytes produce no writes.
- Send 00 00 -> no im_we, load_done=1 and cpu_hold=0 one cycle after second byte.
- rx low 4 cycles (< half bit) then high -> no byte, no state change; then byte 00 00 -> loads normally.
- Send 00 01, 12, then a byte with stop bit low -> frame_err=1, no write; then 00 01 DE AD BE EF -> addr 0 = 0xDEADBEEF, load_done=1.
- AW=2, send 00 05 plus 5 words -> writes at addr 0..3 only, overflow=1, load_done after 5th word; rst pulsed mid-word in a second run -> all outputs back to reset values.
